// File: rtl/module_keypad_scanner.sv
// -----------------------------------------------------------------------------
// module_keypad_scanner
//
// Scan controller for a 4x4 matrix keypad. One column is driven low at a time
// and the active-low rows are sampled once per column step. A candidate key is
// debounced with the column frozen. An accepted key is then reported as
// {row_idx, col_idx} through a valid/ack handshake. Only one key is tracked at
// a time: scanning resumes only after that key has been released and the
// release has been debounced.
//
// Parameters
//   SCAN_DIV    clk cycles per column step (>= 4)
//   DEBOUNCE_N  consecutive identical samples needed for press/release (>= 2)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rows       in   [3:0] keypad rows, active-low, asynchronous to clk
//   columns    out  [3:0] column drive, active-low, exactly one bit low
//   key_code   out  [3:0] {row_idx, col_idx} of the last accepted key
//   key_valid  out  new key available, held until consumed
//   key_ack    in   consumer takes key_code when key_valid & key_ack
//   key_held   out  high while the accepted key is still pressed
//   overrun    out  1-cycle pulse: key accepted while the previous one was unacked
// -----------------------------------------------------------------------------
module module_keypad_scanner #(
    parameter int SCAN_DIV   = 27000,
    parameter int DEBOUNCE_N = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_WAIT_REL  = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    // Registered state
    state_t           state_q;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_s_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       col_q;
    logic [3:0]       columns_q;
    logic [1:0]       row_q;
    logic [3:0]       pat_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
    logic             overrun_q;

    // Combinational helpers
    logic             tick_d;
    logic             sample_ok_d;
    logic [1:0]       row_idx_d;
    logic [1:0]       col_inc_d;
    logic [3:0]       col_drive_d;

    assign tick_d    = (div_q == DIV_LAST);
    assign col_inc_d = col_q + 2'd1;

    // Active-low drive pattern for the column that follows col_q.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col_drive
            assign col_drive_d[gi] = (col_inc_d != 2'(gi));
        end
    endgenerate

    // A sample is usable only when exactly one row is low; idle and
    // multi-key (ghosting) patterns are both treated as "no key".
    always_comb begin
        sample_ok_d = 1'b0;
        row_idx_d   = 2'd0;
        case (rows_s_q)
            4'b1110: begin sample_ok_d = 1'b1; row_idx_d = 2'd0; end
            4'b1101: begin sample_ok_d = 1'b1; row_idx_d = 2'd1; end
            4'b1011: begin sample_ok_d = 1'b1; row_idx_d = 2'd2; end
            4'b0111: begin sample_ok_d = 1'b1; row_idx_d = 2'd3; end
            default: begin sample_ok_d = 1'b0; row_idx_d = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            rows_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
            div_q       <= '0;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            columns_q   <= 4'b1110;
            row_q       <= 2'd0;
            pat_q       <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
            overrun_q   <= 1'b0;

            // Free-running column-step divider.
            if (tick_d) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            // Consumption; an acceptance later in this block takes priority.
            if (key_valid_q && key_ack) begin
                key_valid_q <= 1'b0;
            end

            case (state_q)
                ST_SCAN: begin
                    if (tick_d) begin
                        if (sample_ok_d) begin
                            pat_q   <= rows_s_q;
                            row_q   <= row_idx_d;
                            cnt_q   <= '0;
                            state_q <= ST_DEB_PRESS;
                        end else begin
                            col_q     <= col_inc_d;
                            columns_q <= col_drive_d;
                        end
                    end
                end

                ST_DEB_PRESS: begin
                    if (rows_s_q != pat_q) begin
                        // Bounce: retry the same column on a later tick.
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else if (cnt_q == CNT_LAST) begin
                        key_code_q  <= {row_q, col_q};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        // An ack in this same cycle consumes the old key, so
                        // nothing is lost and no overrun is flagged.
                        overrun_q   <= key_valid_q & ~key_ack;
                        state_q     <= ST_WAIT_REL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_WAIT_REL: begin
                    if (rows_s_q[row_q]) begin
                        cnt_q   <= '0;
                        state_q <= ST_DEB_REL;
                    end
                end

                ST_DEB_REL: begin
                    if (!rows_s_q[row_q]) begin
                        state_q <= ST_WAIT_REL;
                    end else if (cnt_q == CNT_LAST) begin
                        key_held_q <= 1'b0;
                        // Restart the divider so the next column gets a full step.
                        div_q      <= '0;
                        col_q      <= col_inc_d;
                        columns_q  <= col_drive_d;
                        cnt_q      <= '0;
                        state_q    <= ST_SCAN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    assign columns   = columns_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_module_keypad_scanner
//
// Self-checking bench for module_keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=8.
// A keypad model closes the switch at (press_r, press_c): the pressed row reads
// low only while its column is driven low. Expected values come from the
// keypad rules: a key present when its column arrives is accepted
// SCAN_DIV + DEBOUNCE_N clocks later; a release is seen DEBOUNCE_N + 3 clocks
// later (2 synchronizer stages plus the clock that notices the release).
// -----------------------------------------------------------------------------
module tb_module_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 8;
    localparam int PRESS_LAT  = SCAN_DIV + DEBOUNCE_N;
    localparam int REL_LAT    = DEBOUNCE_N + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rows;
    logic [3:0] columns;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    // Keypad model
    logic       pressed;
    logic [1:0] press_r;
    logic [1:0] press_c;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations collected by the stimulus helpers
    logic       obs_to;
    int         obs_lat;
    int         obs_rel_lat;
    int         obs_ovr_cnt;
    int         obs_unfrozen;
    logic [3:0] obs_code;
    logic       obs_valid;
    logic       obs_ovr_at;
    logic [3:0] obs_cols_after;

    always #5 clk = ~clk;

    assign rows = (pressed && (columns[press_c] == 1'b0)) ? ~(4'b0001 << press_r) : 4'b1111;

    module_keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .columns   (columns),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // Active-low column pattern for column c.
    function automatic logic [3:0] col_pattern(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_key();
        key_ack = 1'b1;
        tick1();
        key_ack = 1'b0;
    endtask

    // Press key (r,c) while its column is not driven, then follow it to acceptance.
    // Optionally asserts key_ack in the exact clock of acceptance.
    task automatic press_accept(input logic [1:0] r, input logic [1:0] c, input bit ack_at_accept);
        int guard;
        obs_to = 1'b0; obs_ovr_cnt = 0; obs_unfrozen = 0; obs_lat = 0;
        guard = 0;
        while (columns == col_pattern(c) && guard < 64) begin tick1(); guard++; end
        if (guard >= 64) obs_to = 1'b1;
        press_r = r; press_c = c; pressed = 1'b1;
        guard = 0;
        do begin tick1(); guard++; end while (columns != col_pattern(c) && guard < 64);
        if (guard >= 64) obs_to = 1'b1;
        while (!obs_to) begin
            if (ack_at_accept && obs_lat == PRESS_LAT - 1) key_ack = 1'b1;
            tick1();
            key_ack = 1'b0;
            obs_lat++;
            if (overrun) obs_ovr_cnt++;
            if (key_held) break;
            if (obs_lat >= 64) obs_to = 1'b1;
        end
        obs_code = key_code; obs_valid = key_valid; obs_ovr_at = overrun;
        repeat (20) begin
            tick1();
            if (overrun) obs_ovr_cnt++;
            if (columns != col_pattern(c)) obs_unfrozen++;
        end
    endtask

    task automatic release_key();
        pressed = 1'b0;
        obs_rel_lat = 0;
        while (!obs_to) begin
            tick1();
            obs_rel_lat++;
            if (overrun) obs_ovr_cnt++;
            if (!key_held) break;
            if (obs_rel_lat >= 64) obs_to = 1'b1;
        end
        obs_cols_after = columns;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_ack = 1'b0; pressed = 1'b0; press_r = 2'd0; press_c = 2'd0;
        repeat (3) tick1();
        n_checks++; if (columns !== 4'b1110) $display("FAIL reset_columns: got %b expected 1110", columns); else n_pass++;
        n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++; if (key_code !== 4'd0) $display("FAIL reset_key_code: got %b expected 0000", key_code); else n_pass++;
        n_checks++; if (key_held !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_held_overrun: got %b%b expected 00", key_held, overrun); else n_pass++;
        rst = 1'b0;
        $display("reset: columns=%b key_valid=%b key_code=%b", columns, key_valid, key_code);
    endtask

    // Idle scanning with an ack held high that must be ignored.
    task automatic test_scan();
        logic [3:0] exp_cols;
        key_ack = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick1();
            exp_cols = col_pattern(2'((k / SCAN_DIV) % 4));
            n_checks++; if (columns !== exp_cols) $display("FAIL scan_columns[%0d]: got %b expected %b", k, columns, exp_cols); else n_pass++;
            n_checks++; if (key_valid !== 1'b0) $display("FAIL scan_ack_ignored[%0d]: got key_valid=%b expected 0", k, key_valid); else n_pass++;
        end
        key_ack = 1'b0;
        $display("scan: 16 clocks, columns=%b", columns);
    endtask

    task automatic test_single_press();
        press_accept(2'd2, 2'd2, 1'b0);
        n_checks++; if (obs_to !== 1'b0) $display("FAIL press_timeout: got %b expected 0", obs_to); else n_pass++;
        n_checks++; if (obs_lat !== PRESS_LAT) $display("FAIL press_latency: got %0d expected %0d", obs_lat, PRESS_LAT); else n_pass++;
        n_checks++; if (obs_code !== 4'b1010) $display("FAIL press_code: got %b expected 1010", obs_code); else n_pass++;
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL press_valid: got %b expected 1", obs_valid); else n_pass++;
        n_checks++; if (obs_unfrozen !== 0) $display("FAIL press_frozen: got %0d moves expected 0", obs_unfrozen); else n_pass++;
        n_checks++; if (columns !== 4'b1011) $display("FAIL press_columns: got %b expected 1011", columns); else n_pass++;
        release_key();
        n_checks++; if (obs_to !== 1'b0 || obs_rel_lat !== REL_LAT) $display("FAIL release_latency: got %0d expected %0d", obs_rel_lat, REL_LAT); else n_pass++;
        n_checks++; if (key_held !== 1'b0) $display("FAIL release_held: got %b expected 0", key_held); else n_pass++;
        n_checks++; if (obs_cols_after !== 4'b0111) $display("FAIL release_next_column: got %b expected 0111", obs_cols_after); else n_pass++;
        n_checks++; if (key_valid !== 1'b1 || key_code !== 4'b1010) $display("FAIL release_keeps_key: got %b/%b expected 1/1010", key_valid, key_code); else n_pass++;
        n_checks++; if (obs_ovr_cnt !== 0) $display("FAIL press_no_overrun: got %0d expected 0", obs_ovr_cnt); else n_pass++;
        ack_key();
        n_checks++; if (key_valid !== 1'b0) $display("FAIL press_ack_clears: got %b expected 0", key_valid); else n_pass++;
        $display("single_press: code=%b latency=%0d release_latency=%0d", obs_code, obs_lat, obs_rel_lat);
    endtask

    task automatic test_bounce();
        int bad;
        int guard;
        bad = 0;
        press_r = 2'd2; press_c = 2'd2;
        for (int i = 0; i < 40; i++) begin
            pressed = ((i / 3) % 2 == 0);
            tick1();
            if (key_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bounce_no_valid: got %0d valid clocks expected 0", bad); else n_pass++;
        pressed = 1'b1;
        guard = 0;
        while (!key_held && guard < 80) begin tick1(); guard++; end
        n_checks++; if (key_held !== 1'b1 || key_code !== 4'b1010) $display("FAIL bounce_then_stable: got held=%b code=%b expected 1/1010", key_held, key_code); else n_pass++;
        n_checks++; if (columns !== 4'b1011) $display("FAIL bounce_same_column: got %b expected 1011", columns); else n_pass++;
        obs_to = 1'b0;
        release_key();
        n_checks++; if (key_held !== 1'b0) $display("FAIL bounce_release: got %b expected 0", key_held); else n_pass++;
        ack_key();
        $display("bounce: bad=%0d accepted_after_stable=%b", bad, key_code);
    endtask

    task automatic test_overrun();
        press_accept(2'd0, 2'd0, 1'b0);
        release_key();
        n_checks++; if (obs_ovr_cnt !== 0 || obs_code !== 4'b0000) $display("FAIL overrun_first: got ovr=%0d code=%b expected 0/0000", obs_ovr_cnt, obs_code); else n_pass++;
        press_accept(2'd3, 2'd3, 1'b0);
        n_checks++; if (obs_code !== 4'b1111) $display("FAIL overrun_code: got %b expected 1111", obs_code); else n_pass++;
        n_checks++; if (obs_ovr_at !== 1'b1) $display("FAIL overrun_pulse_at_accept: got %b expected 1", obs_ovr_at); else n_pass++;
        release_key();
        n_checks++; if (obs_ovr_cnt !== 1) $display("FAIL overrun_single_pulse: got %0d expected 1", obs_ovr_cnt); else n_pass++;
        n_checks++; if (key_valid !== 1'b1) $display("FAIL overrun_valid_held: got %b expected 1", key_valid); else n_pass++;
        ack_key();
        n_checks++; if (key_valid !== 1'b0) $display("FAIL overrun_ack_clears: got %b expected 0", key_valid); else n_pass++;
        $display("overrun: code=%b pulses=%0d", obs_code, obs_ovr_cnt);
    endtask

    task automatic test_ack_same_cycle();
        press_accept(2'd1, 2'd2, 1'b0);
        release_key();
        press_accept(2'd2, 2'd1, 1'b1);
        n_checks++; if (obs_lat !== PRESS_LAT) $display("FAIL samecyc_latency: got %0d expected %0d", obs_lat, PRESS_LAT); else n_pass++;
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL samecyc_valid: got %b expected 1", obs_valid); else n_pass++;
        n_checks++; if (obs_code !== 4'b1001) $display("FAIL samecyc_code: got %b expected 1001", obs_code); else n_pass++;
        n_checks++; if (obs_ovr_cnt !== 0) $display("FAIL samecyc_no_overrun: got %0d expected 0", obs_ovr_cnt); else n_pass++;
        n_checks++; if (key_valid !== 1'b1) $display("FAIL samecyc_valid_stays: got %b expected 1", key_valid); else n_pass++;
        release_key();
        ack_key();
        n_checks++; if (key_valid !== 1'b0) $display("FAIL samecyc_ack_clears: got %b expected 0", key_valid); else n_pass++;
        $display("ack_same_cycle: code=%b overrun_pulses=%0d", obs_code, obs_ovr_cnt);
    endtask

    // Random keys with random consumption; the model tracks whether a key is pending.
    task automatic test_random();
        bit         pending;
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] exp_code;
        pending = 1'b0;
        for (int it = 0; it < 8; it++) begin
            r = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                ack_key();
                pending = 1'b0;
                n_checks++; if (key_valid !== 1'b0) $display("FAIL rand_ack[%0d]: got %b expected 0", it, key_valid); else n_pass++;
            end
            exp_code = {r, c};
            press_accept(r, c, 1'b0);
            n_checks++; if (obs_to !== 1'b0 || obs_lat !== PRESS_LAT) $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, obs_lat, PRESS_LAT); else n_pass++;
            n_checks++; if (obs_code !== exp_code || obs_valid !== 1'b1) $display("FAIL rand_code[%0d]: got %b/%b expected %b/1", it, obs_code, obs_valid, exp_code); else n_pass++;
            n_checks++; if (obs_ovr_at !== pending) $display("FAIL rand_overrun_at[%0d]: got %b expected %b", it, obs_ovr_at, pending); else n_pass++;
            release_key();
            n_checks++; if (obs_ovr_cnt !== (pending ? 1 : 0)) $display("FAIL rand_overrun_cnt[%0d]: got %0d expected %0d", it, obs_ovr_cnt, pending ? 1 : 0); else n_pass++;
            n_checks++; if (obs_rel_lat !== REL_LAT) $display("FAIL rand_release[%0d]: got %0d expected %0d", it, obs_rel_lat, REL_LAT); else n_pass++;
            n_checks++; if (obs_cols_after !== col_pattern(c + 2'd1)) $display("FAIL rand_next_col[%0d]: got %b expected %b", it, obs_cols_after, col_pattern(c + 2'd1)); else n_pass++;
            $display("random[%0d]: key=%b pending_before=%b overrun_pulses=%0d", it, exp_code, pending, obs_ovr_cnt);
            pending = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        // Reset while debouncing a press.
        guard = 0;
        while (columns == col_pattern(2'd3) && guard < 64) begin tick1(); guard++; end
        press_r = 2'd1; press_c = 2'd3; pressed = 1'b1;
        guard = 0;
        do begin tick1(); guard++; end while (columns != col_pattern(2'd3) && guard < 64);
        n_checks++; if (guard >= 64) $display("FAIL rstmid_reach_column: got timeout expected column 3"); else n_pass++;
        repeat (SCAN_DIV + 2) tick1();
        rst = 1'b1;
        tick1();
        n_checks++; if (columns !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0 || overrun !== 1'b0)
            $display("FAIL rstmid_deb_press: got cols=%b v=%b h=%b code=%b o=%b expected 1110/0/0/0000/0", columns, key_valid, key_held, key_code, overrun); else n_pass++;
        pressed = 1'b0;
        tick1();
        rst = 1'b0;
        repeat (SCAN_DIV - 1) tick1();
        n_checks++; if (columns !== 4'b1110) $display("FAIL rstmid_restart_col0: got %b expected 1110", columns); else n_pass++;
        tick1();
        n_checks++; if (columns !== 4'b1101) $display("FAIL rstmid_restart_col1: got %b expected 1101", columns); else n_pass++;
        // Reset while waiting for release with a key pending.
        press_accept(2'd0, 2'd2, 1'b0);
        n_checks++; if (obs_valid !== 1'b1 || key_held !== 1'b1) $display("FAIL rstmid_precondition: got v=%b h=%b expected 1/1", obs_valid, key_held); else n_pass++;
        rst = 1'b1;
        tick1();
        n_checks++; if (columns !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0 || overrun !== 1'b0)
            $display("FAIL rstmid_wait_rel: got cols=%b v=%b h=%b code=%b o=%b expected 1110/0/0/0000/0", columns, key_valid, key_held, key_code, overrun); else n_pass++;
        pressed = 1'b0;
        rst = 1'b0;
        repeat (SCAN_DIV) tick1();
        n_checks++; if (columns !== 4'b1101 || key_valid !== 1'b0) $display("FAIL rstmid_rescan: got cols=%b v=%b expected 1101/0", columns, key_valid); else n_pass++;
        $display("reset_mid: columns=%b key_valid=%b", columns, key_valid);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_press();
        test_bounce();
        test_overrun();
        test_ack_same_cycle();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
